// File: rtl/button_event_debouncer.sv
// Five-channel push-button front end: two-flop synchroniser, per-channel
// debounce FSM, clean level/edge outputs and a fixed-priority press-event queue.
module button_event_debouncer #(
  parameter int N_BTN           = 5,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20,
  parameter int IDX_W           = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_n,
  output logic [N_BTN-1:0] pressed,
  output logic [N_BTN-1:0] press_pulse,
  output logic [N_BTN-1:0] release_pulse,
  output logic             ev_valid,
  output logic [IDX_W-1:0] ev_btn,
  input  logic             ev_ready,
  output logic             ev_overflow
);

  typedef enum logic [1:0] {
    UP      = 2'd0,
    WAIT_DN = 2'd1,
    DOWN    = 2'd2,
    WAIT_UP = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_BTN-1:0] s1, s2;
  logic [N_BTN-1:0] accept_press;
  logic [N_BTN-1:0] pending;
  logic [N_BTN-1:0] grant;

  // Raw pins are asynchronous; s2 is the only copy the debouncer may look at.
  // NOTE: all sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= '1;
      s2 <= '1;
    end else begin
      s1 <= btn_n;
      s2 <= s1;
    end
  end

  for (genvar g = 0; g < N_BTN; g++) begin : g_chan
    state_e           state;
    logic [CNT_W-1:0] cnt;

    assign accept_press[g] = (state == WAIT_DN) && !s2[g] && (cnt == CNT_LAST);

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state            <= UP;
        cnt              <= '0;
        pressed[g]       <= 1'b0;
        press_pulse[g]   <= 1'b0;
        release_pulse[g] <= 1'b0;
      end else begin
        press_pulse[g]   <= 1'b0;
        release_pulse[g] <= 1'b0;
        unique case (state)
          UP: begin
            if (!s2[g]) begin
              state <= WAIT_DN;
              cnt   <= CNT_W'(1);
            end
          end
          WAIT_DN: begin
            if (s2[g]) begin
              state <= UP;
              cnt   <= '0;
            end else if (cnt == CNT_LAST) begin
              state          <= DOWN;
              cnt            <= '0;
              pressed[g]     <= 1'b1;
              press_pulse[g] <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          DOWN: begin
            if (s2[g]) begin
              state <= WAIT_UP;
              cnt   <= CNT_W'(1);
            end
          end
          WAIT_UP: begin
            if (!s2[g]) begin
              state <= DOWN;
              cnt   <= '0;
            end else if (cnt == CNT_LAST) begin
              state            <= UP;
              cnt              <= '0;
              pressed[g]       <= 1'b0;
              release_pulse[g] <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          default: begin
            state <= UP;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

  // Fixed priority: lowest pending index is offered; scan downward so it wins.
  // NOTE: every combinational output gets a default before any conditional
  // assignment, so no latch is inferred.
  always_comb begin
    ev_btn = '0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (pending[i]) ev_btn = IDX_W'(i);
    end
  end

  assign ev_valid = |pending;
  assign grant    = (ev_valid && ev_ready) ? (N_BTN'(1) << ev_btn) : '0;

  // A press landing on the edge its own event is granted re-arms the bit
  // instead of counting as lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending     <= '0;
      ev_overflow <= 1'b0;
    end else begin
      pending <= (pending & ~grant) | accept_press;
      if (|(accept_press & pending & ~grant)) ev_overflow <= 1'b1;
    end
  end

endmodule
